// File: rtl/imem_pkg.sv
// Shared types and address-legality helper for the instruction-memory responder.
package imem_pkg;

    localparam int IMEM_DWIDTH      = 32;
    localparam int IMEM_DEPTH_WORDS = 1024;
    localparam int IMEM_IDX_W       = $clog2(IMEM_DEPTH_WORDS);

    typedef struct packed {
        logic [IMEM_DWIDTH-1:0] data;
        logic                   err;
    } imem_rsp_t;

    // Operands are widened to 64 bits so base + span cannot wrap for any AWIDTH <= 63.
    function automatic logic addr_ok(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] span);
        return (addr[1:0] == 2'b00) && (addr >= base) && (addr < base + span);
    endfunction

endpackage

// File: rtl/imem_responder_sync_fifo.sv
// Synchronous FIFO with first-word fall-through; head entry is always on rdata.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    assign rdata = store[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory: in-order word reads with fixed latency,
// buffered responses for backpressure, and a preload write port.
module imem_responder
    import imem_pkg::*;
#(
    parameter int                DWIDTH      = 32,
    parameter int                AWIDTH      = 32,
    parameter logic [AWIDTH-1:0] BASEADDR    = 32'h01000000,
    parameter int                DEPTH_WORDS = 1024,
    parameter int                LATENCY     = 2,
    parameter int                RSP_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AWIDTH-1:0] req_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DWIDTH-1:0] rsp_data_o,
    output logic              rsp_err_o,
    input  logic              wr_en_i,
    input  logic [AWIDTH-1:0] wr_addr_i,
    input  logic [DWIDTH-1:0] wr_data_i
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam int          CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [63:0] SPAN  = 64'(DEPTH_WORDS) * 64'd4;

    logic [DWIDTH-1:0] mem [DEPTH_WORDS];
    logic [CNT_W-1:0]  out_cnt;
    logic              accept;
    logic              consume;
    logic              rd_ok;
    logic              wr_ok;
    logic              bypass;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;

    logic              vld_p0;
    logic              err_p0;
    logic [DWIDTH-1:0] data_p0;
    logic [LATENCY-1:0] vld_p;
    logic [LATENCY-1:0] err_p;
    logic [DWIDTH-1:0] data_p [LATENCY];

    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DWIDTH:0]   fifo_head;

    // Ready comes from the registered count, so a consume frees a slot only next cycle.
    assign req_ready_o = rst && (out_cnt < CNT_W'(RSP_DEPTH));
    assign accept      = req_valid_i && req_ready_o;
    assign consume     = rsp_valid_o && rsp_ready_i;

    assign rd_ok  = addr_ok(64'(req_addr_i), 64'(BASEADDR), SPAN);
    assign wr_ok  = addr_ok(64'(wr_addr_i), 64'(BASEADDR), SPAN);
    assign rd_idx = IDX_W'((req_addr_i - BASEADDR) >> 2);
    assign wr_idx = IDX_W'((wr_addr_i - BASEADDR) >> 2);
    assign bypass = wr_en_i && wr_ok && (wr_idx == rd_idx);

    always_ff @(posedge clk) begin
        if (wr_en_i && wr_ok) mem[wr_idx] <= wr_data_i;
    end

    // Stage p0: array read in the accept cycle, with write-first bypass
    always_comb begin
        vld_p0  = accept;
        err_p0  = !rd_ok;
        data_p0 = '0;
        if (rd_ok) data_p0 = bypass ? wr_data_i : mem[rd_idx];
    end

    // Stages p1..pLATENCY: delay line, last stage feeds the response FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= vld_p0;
            for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        data_p[0] <= data_p0;
        err_p[0]  <= err_p0;
        for (int i = 1; i < LATENCY; i++) begin
            data_p[i] <= data_p[i-1];
            err_p[i]  <= err_p[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_cnt <= '0;
        end else if (accept && !consume) begin
            out_cnt <= out_cnt + CNT_W'(1);
        end else if (!accept && consume) begin
            out_cnt <= out_cnt - CNT_W'(1);
        end
    end

    // The outstanding limit keeps the FIFO from being full when a result arrives.
    assign fifo_push = vld_p[LATENCY-1] && (!fifo_full || consume);

    sync_fifo #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (consume),
        .wdata ({err_p[LATENCY-1], data_p[LATENCY-1]}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Output stage: FIFO head, forced to zero when nothing is buffered
    assign rsp_valid_o              = !fifo_empty;
    assign {rsp_err_o, rsp_data_o}  = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder (default parameters).
module tb_imem_responder;

    localparam logic [31:0] BASE      = 32'h01000000;
    localparam logic [31:0] LAST_WORD = 32'h5A5A1023;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_responder #(
        .DWIDTH      (32),
        .AWIDTH      (32),
        .BASEADDR    (32'h01000000),
        .DEPTH_WORDS (1024),
        .LATENCY     (2),
        .RSP_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data)
    );

    function automatic logic [31:0] word_val(input int i);
        if (i == 0) return 32'h00000013;
        return 32'hA5000000 + 32'(i);
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    // Single isolated read with FIFO empty; returns what appears LATENCY edges later.
    task automatic do_read(input logic [31:0] a, output logic v,
                           output logic [31:0] d, output logic e);
        req_valid = 1'b1;
        req_addr  = a;
        rsp_ready = 1'b0;
        cyc();
        req_valid = 1'b0;
        cyc();
        cyc();
        v = rsp_valid;
        d = rsp_data;
        e = rsp_err;
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #3 rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ready=%b valid=%b data=%h err=%b, want 0 0 00000000 0",
                     req_ready, rsp_valid, rsp_data, rsp_err);
        end
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_addr = BASE + 32'(4 * i); wr_data = word_val(i);
            cyc();
        end
        wr_en = 1'b1; wr_addr = BASE + 32'h00000FFC; wr_data = LAST_WORD;
        cyc();
        wr_en = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: ready=%b valid=%b, want 0 0", req_ready, rsp_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b want 1", req_ready);
        end
    endtask

    task automatic test_first_fetch();
        req_valid = 1'b1; req_addr = BASE; rsp_ready = 1'b0;
        cyc();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_lat1: valid=%b want 0", rsp_valid);
        end
        cyc();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_lat2: valid=%b want 0", rsp_valid);
        end
        cyc();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h00000013 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL first_fetch: valid=%b data=%h err=%b, want 1 00000013 0",
                     rsp_valid, rsp_data, rsp_err);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_consumed: valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] exp;
        rsp_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            req_valid = (c < 10);
            req_addr  = BASE + 32'(4 * c);
            if (c < 10) begin
                checks++;
                if (req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_ready c=%0d: got %b want 1", c, req_ready);
                end
            end
            cyc();
            checks++;
            if (c >= 2 && c < 12) begin
                exp = word_val(c - 2);
                if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_rsp c=%0d: valid=%b data=%h err=%b, want 1 %h 0",
                             c, rsp_valid, rsp_data, rsp_err, exp);
                end
            end else if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_idle c=%0d: valid=%b want 0", c, rsp_valid);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = BASE;
        for (int c = 0; c < 8; c++) begin
            if (req_ready === 1'b1) acc++;
            cyc();
            req_addr = BASE + 32'(4 * acc);
        end
        req_valid = 1'b0;
        checks++;
        if (acc != 4 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accepts: accepted=%0d ready=%b, want 4 0", acc, req_ready);
        end
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== word_val(0) || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall s=%0d: valid=%b data=%h, want 1 %h",
                         s, rsp_valid, rsp_data, word_val(0));
            end
            cyc();
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_return: got %b want 1", req_ready);
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== word_val(k)) begin
                errors++;
                $display("FAIL bp_drain k=%0d: valid=%b data=%h, want 1 %h",
                         k, rsp_valid, rsp_data, word_val(k));
            end
            rsp_ready = 1'b1;
            cyc();
        end
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        logic        exp_err [4];
        logic [31:0] exp_data [4];
        logic        v;
        logic [31:0] d;
        logic        e;
        addrs[0] = 32'h01000002; exp_err[0] = 1'b1; exp_data[0] = 32'h0;
        addrs[1] = 32'h00FFFFFC; exp_err[1] = 1'b1; exp_data[1] = 32'h0;
        addrs[2] = 32'h01001000; exp_err[2] = 1'b1; exp_data[2] = 32'h0;
        addrs[3] = 32'h01000FFC; exp_err[3] = 1'b0; exp_data[3] = LAST_WORD;
        for (int i = 0; i < 4; i++) begin
            do_read(addrs[i], v, d, e);
            checks++;
            if (v !== 1'b1 || e !== exp_err[i] || d !== exp_data[i]) begin
                errors++;
                $display("FAIL err_check addr=%h: valid=%b err=%b data=%h, want 1 %b %h",
                         addrs[i], v, e, d, exp_err[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_collision();
        logic        v;
        logic [31:0] d;
        logic        e;
        wr_en = 1'b1; wr_addr = BASE + 32'h10; wr_data = 32'hDEADBEEF;
        req_valid = 1'b1; req_addr = BASE + 32'h10; rsp_ready = 1'b0;
        cyc();
        wr_en = 1'b0; req_valid = 1'b0;
        cyc();
        cyc();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL collision: valid=%b data=%h err=%b, want 1 deadbeef 0",
                     rsp_valid, rsp_data, rsp_err);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        wr_en = 1'b1; wr_addr = 32'h00000000; wr_data = 32'hBAD0BAD0;
        cyc();
        wr_en = 1'b0;
        do_read(BASE, v, d, e);
        checks++;
        if (v !== 1'b1 || d !== 32'h00000013 || e !== 1'b0) begin
            errors++;
            $display("FAIL illegal_write: valid=%b data=%h err=%b, want 1 00000013 0", v, d, e);
        end
        do_read(BASE + 32'h10, v, d, e);
        checks++;
        if (v !== 1'b1 || d !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL collision_stored: valid=%b data=%h err=%b, want 1 deadbeef 0", v, d, e);
        end
    endtask

    task automatic test_mid_reset();
        logic        v;
        logic [31:0] d;
        logic        e;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1; req_addr = BASE + 32'(4 * k);
            cyc();
        end
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== word_val(0)) begin
            errors++;
            $display("FAIL pre_reset: valid=%b data=%h, want 1 %h", rsp_valid, rsp_data, word_val(0));
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: ready=%b valid=%b data=%h err=%b, want 0 0 00000000 0",
                     req_ready, rsp_valid, rsp_data, rsp_err);
        end
        cyc();
        rst = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL stale_rsp c=%0d: valid=%b ready=%b, want 0 1", c, rsp_valid, req_ready);
            end
        end
        rsp_ready = 1'b0;
        do_read(BASE, v, d, e);
        checks++;
        if (v !== 1'b1 || d !== 32'h00000013 || e !== 1'b0) begin
            errors++;
            $display("FAIL mem_survives0: valid=%b data=%h err=%b, want 1 00000013 0", v, d, e);
        end
        do_read(BASE + 32'h24, v, d, e);
        checks++;
        if (v !== 1'b1 || d !== word_val(9) || e !== 1'b0) begin
            errors++;
            $display("FAIL mem_survives9: valid=%b data=%h err=%b, want 1 %h 0", v, d, e, word_val(9));
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_streaming();
        test_backpressure();
        test_errors();
        test_collision();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
